// File: rtl/jpeg_idct_block_arb.sv
// Round-robin arbiter granting whole sample blocks from two requesters to the IDCT input FIFO.
// Define JPEG_IDCT_ARB_STATS_EN to enable the completed-block counter on blocks_o.
module jpeg_idct_block_arb #(
    parameter int WIDTH       = 16,
    parameter int BLOCK_BEATS = 64,
    parameter int BEAT_W      = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req0_valid_i,
    input  logic [WIDTH-1:0] req0_data_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [WIDTH-1:0] req1_data_i,
    output logic             req1_ready_o,
    output logic             fifo_push_o,
    output logic [WIDTH-1:0] fifo_data_o,
    input  logic             fifo_accept_i,
    output logic             owner_o,
    output logic             busy_o,
    output logic [15:0]      blocks_o
);
    typedef enum logic {IDLE, OWN} state_t;

    state_t            state_q;
    logic [BEAT_W-1:0] beat_q;
    logic              last_q;
    logic              owner_q;

    logic              own_st;
    logic              own_valid;
    logic [WIDTH-1:0]  own_data;
    logic              beat_xfer;
    logic              last_beat;
    logic              grant;

    // Push depends only on the owner's valid, never on fifo_accept_i.
    assign own_st       = (state_q == OWN);
    assign own_valid    = owner_q ? req1_valid_i : req0_valid_i;
    assign own_data     = owner_q ? req1_data_i : req0_data_i;
    assign fifo_push_o  = own_st & own_valid;
    assign fifo_data_o  = own_st ? own_data : '0;
    assign req0_ready_o = own_st & ~owner_q & fifo_accept_i;
    assign req1_ready_o = own_st & owner_q & fifo_accept_i;
    assign beat_xfer    = fifo_push_o & fifo_accept_i;
    assign last_beat    = (beat_q == BEAT_W'(BLOCK_BEATS - 1));
    assign grant        = (req0_valid_i & req1_valid_i) ? ~last_q : req1_valid_i;
    assign busy_o       = own_st;
    assign owner_o      = owner_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            beat_q  <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_valid_i | req1_valid_i) begin
                        owner_q <= grant;
                        beat_q  <= '0;
                        state_q <= OWN;
                    end
                end
                OWN: begin
                    if (beat_xfer) begin
                        if (last_beat) begin
                            state_q <= IDLE;
                            last_q  <= owner_q;
                            beat_q  <= '0;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef JPEG_IDCT_ARB_STATS_EN
    logic [15:0] blocks_q;

    // Wraps naturally from 0xFFFF to 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blocks_q <= '0;
        end else if (flush_i) begin
            blocks_q <= '0;
        end else if (beat_xfer && last_beat) begin
            blocks_q <= blocks_q + 16'd1;
        end
    end

    assign blocks_o = blocks_q;
`else
    assign blocks_o = '0;
`endif

endmodule

// File: tb/tb_jpeg_idct_block_arb.sv
// Bench for jpeg_idct_block_arb: table-driven arbitration sequence plus directed flush/reset/wrap cases.
module tb_jpeg_idct_block_arb;
    localparam int WIDTH       = 16;
    localparam int BLOCK_BEATS = 64;
    localparam int BEAT_W      = 6;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             req0_valid_i;
    logic [WIDTH-1:0] req0_data_i;
    logic             req0_ready_o;
    logic             req1_valid_i;
    logic [WIDTH-1:0] req1_data_i;
    logic             req1_ready_o;
    logic             fifo_push_o;
    logic [WIDTH-1:0] fifo_data_o;
    logic             fifo_accept_i;
    logic             owner_o;
    logic             busy_o;
    logic [15:0]      blocks_o;

    always #5 clk_i = ~clk_i;

    jpeg_idct_block_arb #(
        .WIDTH      (WIDTH),
        .BLOCK_BEATS(BLOCK_BEATS),
        .BEAT_W     (BEAT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .req0_valid_i (req0_valid_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .fifo_push_o  (fifo_push_o),
        .fifo_data_o  (fifo_data_o),
        .fifo_accept_i(fifo_accept_i),
        .owner_o      (owner_o),
        .busy_o       (busy_o),
        .blocks_o     (blocks_o)
    );

    int               n_vec = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic             m_owner;
    logic [15:0]      m_blocks;

    typedef struct {
        logic v0;
        logic v1;
        logic exp_owner;
    } arb_vec_t;

    arb_vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic count_block();
`ifdef JPEG_IDCT_ARB_STATS_EN
        m_blocks = m_blocks + 16'd1;
`endif
    endtask

    // Scoreboard: every accepted push must match the next queued sample.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && fifo_push_o && fifo_accept_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL fifo_data: unexpected push of %0h, expected no push", fifo_data_o);
            end else begin
                check("fifo_data", 32'(fifo_data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_push"},   32'(fifo_push_o),  0);
        check({tag, "_data"},   32'(fifo_data_o),  0);
        check({tag, "_ready0"}, 32'(req0_ready_o), 0);
        check({tag, "_ready1"}, 32'(req1_ready_o), 0);
        check({tag, "_owner"},  32'(owner_o),      0);
        check({tag, "_busy"},   32'(busy_o),       0);
        check({tag, "_blocks"}, 32'(blocks_o),     0);
    endtask

    task automatic do_reset();
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        req0_valid_i  = 1'b0;
        req1_valid_i  = 1'b0;
        fifo_accept_i = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni   = 1'b1;
        m_owner  = 1'b0;
        m_blocks = 16'd0;
    endtask

    // One arbitration cycle, then up to 'beats' transfers from requester 'who'.
    task automatic run_block(input logic who, input bit toggle, input int beats, input logic idle_owner);
        int got = 0;
        int budget = 0;
        bit hs;
        @(negedge clk_i);
        check("idle_busy",   32'(busy_o),       0);
        check("idle_push",   32'(fifo_push_o),  0);
        check("idle_data",   32'(fifo_data_o),  0);
        check("idle_ready0", 32'(req0_ready_o), 0);
        check("idle_ready1", 32'(req1_ready_o), 0);
        check("idle_owner",  32'(owner_o),      32'(idle_owner));
        check("idle_blocks", 32'(blocks_o),     32'(m_blocks));
        @(posedge clk_i);
        #1;
        exp_q.push_back(who ? req1_data_i : req0_data_i);
        while (got < beats && budget < 4 * BLOCK_BEATS) begin
            @(negedge clk_i);
            check("own_busy",  32'(busy_o),  1);
            check("own_owner", 32'(owner_o), 32'(who));
            check("own_push",  32'(fifo_push_o), 1);
            check("own_ready", 32'(who ? req1_ready_o : req0_ready_o), 32'(fifo_accept_i));
            check("other_ready", 32'(who ? req0_ready_o : req1_ready_o), 0);
            hs = fifo_push_o && fifo_accept_i;
            @(posedge clk_i);
            #1;
            budget++;
            if (hs) begin
                got++;
                if (who) req1_data_i = req1_data_i + 16'h0107;
                else     req0_data_i = req0_data_i + 16'h0013;
                if (got < beats) exp_q.push_back(who ? req1_data_i : req0_data_i);
            end
            if (toggle) fifo_accept_i = ~fifo_accept_i;
        end
        if (got < beats) begin
            n_vec++;
            n_err++;
            $display("FAIL block_timeout: got %0d beats, expected %0d", got, beats);
        end
        fifo_accept_i = 1'b1;
        m_owner = who;
        if (got == BLOCK_BEATS) count_block();
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1};

        req0_data_i = 16'h1000;
        req1_data_i = 16'hA000;
        do_reset();

        // Single block, no stalls.
        req0_valid_i = 1'b1;
        run_block(1'b0, 1'b0, BLOCK_BEATS, 1'b0);
        req0_valid_i = 1'b0;
        @(negedge clk_i);
        check("single_busy_after", 32'(busy_o), 0);
        check("single_blocks", 32'(blocks_o), 32'(m_blocks));
        @(posedge clk_i);
        #1;

        // Contention and round-robin sequence from the table.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            req0_valid_i = tbl[i].v0;
            req1_valid_i = tbl[i].v1;
            run_block(tbl[i].exp_owner, 1'b0, BLOCK_BEATS, m_owner);
        end

        // Backpressure on a req1 block.
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b1;
        run_block(1'b1, 1'b1, BLOCK_BEATS, m_owner);

        // Mid-block flush at beat 20 of a req0 block.
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b0;
        run_block(1'b0, 1'b0, 20, m_owner);
        flush_i = 1'b1;
        exp_q.push_back(req0_data_i);
        @(negedge clk_i);
        check("flush_push", 32'(fifo_push_o), 1);
        @(posedge clk_i);
        #1;
        flush_i      = 1'b0;
        req0_data_i  = req0_data_i + 16'h0013;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b1;
        m_owner      = 1'b0;
        m_blocks     = 16'd0;
        run_block(1'b1, 1'b0, BLOCK_BEATS, 1'b0);

        // Leave last_q at 0, then reset in the middle of a req0 block.
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b0;
        run_block(1'b0, 1'b0, BLOCK_BEATS, m_owner);
        run_block(1'b0, 1'b0, 40, m_owner);
        rst_ni = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk_i);
        #1;
        rst_ni       = 1'b1;
        m_owner      = 1'b0;
        m_blocks     = 16'd0;
        req1_valid_i = 1'b1;
        run_block(1'b0, 1'b0, BLOCK_BEATS, 1'b0);

        // Counter wrap.
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
`ifdef JPEG_IDCT_ARB_STATS_EN
        force dut.blocks_q = 16'hFFFF;
        @(posedge clk_i);
        #1;
        release dut.blocks_q;
        m_blocks = 16'hFFFF;
`endif
        req1_valid_i = 1'b1;
        run_block(1'b1, 1'b0, BLOCK_BEATS, m_owner);
        req1_valid_i = 1'b0;
        @(negedge clk_i);
        check("wrap_blocks", 32'(blocks_o), 32'(m_blocks));
        check("final_busy", 32'(busy_o), 0);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/jpeg_idct_block_arb.md
JPEG_IDCT_BLOCK_ARB -- requirements
Module: jpeg_idct_block_arb

Interface
REQ-001 The block SHALL have the following parameters:
  - WIDTH, default 16: sample width.
  - BLOCK_BEATS, default 64: samples per block; power of two, at least 2.
  - BEAT_W, default 6: log2(BLOCK_BEATS).
REQ-002 The block SHALL have the following ports; it has one clock, and its reset is asynchronous and active-low:
  - clk_i  in  1  clock, rising edge.
  - rst_ni  in  1  asynchronous reset, active-low.
  - flush_i  in  1  synchronous abort and return to idle.
  - req0_valid_i  in  1  requester 0 sample valid.
  - req0_data_i  in  WIDTH  requester 0 sample.
  - req0_ready_o  out  1  requester 0 sample taken.
  - req1_valid_i  in  1  requester 1 sample valid.
  - req1_data_i  in  WIDTH  requester 1 sample.
  - req1_ready_o  out  1  requester 1 sample taken.
  - fifo_push_o  out  1  push to the downstream IDCT FIFO.
  - fifo_data_o  out  WIDTH  data to the FIFO.
  - fifo_accept_i  in  1  FIFO has space.
  - owner_o  out  1  index of the requester currently granted.
  - busy_o  out  1  a block is in progress.
  - blocks_o  out  16  completed-block count.

Function
REQ-003 The controller SHALL use two states, IDLE and OWN; busy_o is 1 exactly when the state is OWN.
REQ-004 In IDLE, fifo_push_o and both ready outputs SHALL be 0.
REQ-005 In IDLE, if any reqN_valid_i is 1, the arbiter SHALL select an owner and enter OWN on the next edge, with the beat counter at 0.
  - One arbitration cycle is spent per block.
REQ-006 Selection SHALL be round-robin:
  - If both requesters are valid, grant ~last_q.
  - If only one is valid, grant that one.
  - last_q is the owner of the most recently completed block.
REQ-007 In OWN, the datapath SHALL be:
  - fifo_push_o = reqOWNER_valid_i.
  - fifo_data_o = reqOWNER_data_i.
  - reqOWNER_ready_o = fifo_accept_i.
  - The non-owner's ready output = 0.
REQ-008 fifo_data_o SHALL be driven to 0 in IDLE.
REQ-009 A beat SHALL transfer when reqOWNER_valid_i and fifo_accept_i are both 1.
  - The beat counter increments by 1 per beat.
  - Stalls on either side hold all state.
REQ-010 On the beat where the counter equals BLOCK_BEATS-1, the block SHALL:
  - return to IDLE;
  - set last_q to the owner;
  - clear the beat counter;
  - increment blocks_o.
REQ-011 Ownership SHALL never change mid-block, regardless of the other requester's valid.
REQ-012 owner_o SHALL hold its value in IDLE.
REQ-013 blocks_o SHALL wrap from 0xFFFF to 0x0000.
REQ-014 flush_i SHALL have priority over all other events in the same cycle.
  - On the next edge: state IDLE, beat counter 0, last_q 1, owner_o 0, blocks_o 0.
  - A beat presented in the flush cycle is still handed to the FIFO, because the outputs are combinational, but it is not counted.
REQ-015 The block SHALL contain no combinational path from fifo_accept_i to fifo_push_o.

Reset
REQ-016 Asserting rst_ni low SHALL asynchronously force: state IDLE, beat counter 0, last_q 1, owner_o 0, blocks_o 0.
REQ-017 In reset, all outputs SHALL be 0, including mid-block.
  - A partially transferred block is discarded.
  - Downstream flushing is the system's responsibility.
REQ-018 After rst_ni rises, the first block granted with both requesters valid SHALL go to requester 0.

Configuration
REQ-019 When JPEG_IDCT_ARB_STATS_EN is defined, blocks_o SHALL be a live 16-bit counter per REQ-010, REQ-013 and REQ-014.
REQ-020 When JPEG_IDCT_ARB_STATS_EN is undefined, blocks_o SHALL be constant 0 and no counter flops SHALL be synthesized; all other behaviour is identical.

Verification
REQ-021 The bench SHALL cover the following directed scenarios (BLOCK_BEATS=64, JPEG_IDCT_ARB_STATS_EN defined):
  - Single block, no stalls: after reset, req0 valid for 64 beats with fifo_accept_i=1 -> exactly 64 pushes with matching data, busy_o low on the cycle after beat 63, blocks_o=1.
  - Contention: both requesters valid continuously -> blocks granted 0,1,0,1; each grant is 64 beats; 1 idle cycle between blocks; blocks_o=4 after 260 cycles.
  - Backpressure: fifo_accept_i toggles every cycle during a req1 block -> req1_ready_o mirrors accept, 64 transfers, no duplicate or lost sample, ownership held throughout.
  - Mid-block flush: flush_i at beat 20 of a req0 block -> next cycle IDLE, blocks_o=0, req1 (valid) granted after one arbitration cycle.
  - Async reset mid-block: rst_ni low at beat 40 -> all outputs 0 within the same cycle; after release, with both valid, req0 is granted first.
  - Wrap: blocks_o preloaded by running 65535 blocks (or by force) plus one block -> blocks_o=0x0000; with the macro undefined, blocks_o stays 0.
